// File: rtl/btn_evt_pkg.sv
// Shared event codes, channel state encoding and width helper for the button event scheduler.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StDown = 2'b01,
    StHeld = 2'b10
  } ch_state_e;

  // Ceiling log2, floored at 1 so every derived vector has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous FIFO with full/empty flags; read data is the head entry.
module btn_evt_fifo import btn_evt_pkg::*; #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop never frees room for a push in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/btn_evt_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events, arbitrated
// round-robin into a small FIFO drained over valid/ready.
module btn_evt_ctrl import btn_evt_pkg::*; #(
  parameter int unsigned NBTN         = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NBTN-1:0]          btn_i,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [clog2(NBTN)-1:0]   evt_btn,
  output logic [1:0]               evt_type,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int unsigned IW = clog2(NBTN);
  localparam int unsigned PW = clog2(TICK_DIV);
  localparam int unsigned HW = clog2((LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS);

  logic [PW-1:0]   presc_q;
  logic            tick;
  logic [NBTN-1:0] prev_q, rise, fall;
  logic [NBTN-1:0] post;
  logic [1:0]      post_type [NBTN];
  logic [NBTN-1:0] pend_q, pend_d;
  logic [1:0]      ptype_q [NBTN];
  logic [1:0]      ptype_d [NBTN];
  logic [IW-1:0]   rr_q, gnt_idx, cand;
  logic            gnt_vld, ovf_set, overflow_q;
  logic            fifo_full, fifo_empty;
  logic [IW+1:0]   head;

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign rise = btn_i & ~prev_q;
  assign fall = ~btn_i & prev_q;

  // Per-channel FSM; posts are registered, so they reach the pending slot one edge later.
  for (genvar g = 0; g < int'(NBTN); g++) begin : g_ch
    ch_state_e     st_q;
    logic [HW-1:0] hold_q;
    logic          post_q;
    logic [1:0]    post_type_q;

    assign post[g]      = post_q;
    assign post_type[g] = post_type_q;

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        st_q        <= StIdle;
        hold_q      <= '0;
        post_q      <= 1'b0;
        post_type_q <= EVT_PRESS;
      end else begin
        post_q <= 1'b0;
        case (st_q)
          StIdle: begin
            if (rise[g]) begin
              st_q        <= StDown;
              hold_q      <= '0;
              post_q      <= 1'b1;
              post_type_q <= EVT_PRESS;
            end
          end
          StDown, StHeld: begin
            if (fall[g]) begin
              st_q        <= StIdle;
              hold_q      <= '0;
              post_q      <= 1'b1;
              post_type_q <= EVT_RELEASE;
            end else if (tick) begin
              if (st_q == StDown && hold_q == HW'(LONG_TICKS - 1)) begin
                st_q        <= StHeld;
                hold_q      <= '0;
                post_q      <= 1'b1;
                post_type_q <= EVT_LONG;
              end else if (st_q == StHeld && hold_q == HW'(REPEAT_TICKS - 1)) begin
                hold_q      <= '0;
                post_q      <= 1'b1;
                post_type_q <= EVT_REPEAT;
              end else begin
                hold_q <= hold_q + HW'(1);
              end
            end
          end
          default: st_q <= StIdle;
        endcase
      end
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    for (int k = 1; k <= int'(NBTN); k++) begin
      cand = IW'((int'(rr_q) + k) % int'(NBTN));
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (fifo_full) gnt_vld = 1'b0;
  end

  always_comb begin
    ovf_set = 1'b0;
    for (int k = 0; k < int'(NBTN); k++) begin
      pend_d[k]  = pend_q[k];
      ptype_d[k] = ptype_q[k];
      if (post[k]) begin
        if (pend_q[k] && !(gnt_vld && gnt_idx == IW'(k))) ovf_set = 1'b1;
        pend_d[k]  = 1'b1;
        ptype_d[k] = post_type[k];
      end else if (gnt_vld && gnt_idx == IW'(k)) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      presc_q    <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      for (int k = 0; k < int'(NBTN); k++) ptype_q[k] <= EVT_PRESS;
      rr_q       <= IW'(NBTN - 1);
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= tick ? '0 : presc_q + PW'(1);
      prev_q     <= btn_i;
      pend_q     <= pend_d;
      for (int k = 0; k < int'(NBTN); k++) ptype_q[k] <= ptype_d[k];
      if (gnt_vld) rr_q <= gnt_idx;
      overflow_q <= ovf_set | (overflow_q & ~clr_ovf);
    end
  end

  btn_evt_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (IW + 2)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (gnt_vld),
    .wdata_i ({gnt_idx, ptype_q[gnt_idx]}),
    .pop_i   (evt_valid & evt_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_btn   = head[IW+1:2];
  assign evt_type  = head[1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// Directed and random stimulus for btn_evt_ctrl, checked every cycle against an
// event-level reference model (tick counting per press, pending slots, FIFO queue).
module tb_btn_evt_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int LT = 3;
  localparam int RT = 2;
  localparam int FD = 4;

  localparam int T_PRESS   = 0;
  localparam int T_RELEASE = 1;
  localparam int T_LONG    = 2;
  localparam int T_REPEAT  = 3;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [N-1:0] btn_i = '0;
  logic         evt_valid;
  logic         evt_ready = 1'b1;
  logic [1:0]   evt_btn;
  logic [1:0]   evt_type;
  logic         overflow;
  logic         clr_ovf = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int presc;
  bit m_prev [N];
  int m_ticks [N];
  bit m_post [N];
  int m_post_t [N];
  bit m_pend [N];
  int m_ptype [N];
  int m_rr;
  bit m_ovf;
  int q_btn [$];
  int q_typ [$];

  always #5 clk = ~clk;

  btn_evt_ctrl #(
    .NBTN         (N),
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .btn_i     (btn_i),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_btn   (evt_btn),
    .evt_type  (evt_type),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Applies one clock edge worth of the event rules to the model, using pre-edge inputs.
  task automatic model_edge();
    int  g;
    int  gt;
    bit  full;
    bit  pop;
    bit  ovf_set;
    bit  tk;
    bit  b;
    if (!n_rst) begin
      presc = 0;
      m_rr  = N - 1;
      m_ovf = 1'b0;
      q_btn.delete();
      q_typ.delete();
      for (int c = 0; c < N; c++) begin
        m_prev[c] = 1'b0; m_ticks[c] = 0; m_post[c] = 1'b0; m_post_t[c] = 0;
        m_pend[c] = 1'b0; m_ptype[c] = 0;
      end
      return;
    end
    g    = -1;
    gt   = 0;
    full = (q_btn.size() == FD);
    pop  = (q_btn.size() > 0) && evt_ready;
    if (!full) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (g >= 0) gt = m_ptype[g];
    ovf_set = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (m_post[c]) begin
        if (m_pend[c] && g != c) ovf_set = 1'b1;
        m_pend[c]  = 1'b1;
        m_ptype[c] = m_post_t[c];
      end else if (g == c) begin
        m_pend[c] = 1'b0;
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (pop) begin
      void'(q_btn.pop_front());
      void'(q_typ.pop_front());
    end
    if (g >= 0) begin
      q_btn.push_back(g);
      q_typ.push_back(gt);
      m_rr = g;
    end
    tk = (presc == TD - 1);
    for (int c = 0; c < N; c++) begin
      b = btn_i[c];
      m_post[c] = 1'b0;
      if (b && !m_prev[c]) begin
        m_post[c] = 1'b1; m_post_t[c] = T_PRESS; m_ticks[c] = 0;
      end else if (!b && m_prev[c]) begin
        m_post[c] = 1'b1; m_post_t[c] = T_RELEASE;
      end else if (b && tk) begin
        m_ticks[c]++;
        if (m_ticks[c] == LT) begin
          m_post[c] = 1'b1; m_post_t[c] = T_LONG;
        end else if (m_ticks[c] > LT && (m_ticks[c] - LT) % RT == 0) begin
          m_post[c] = 1'b1; m_post_t[c] = T_REPEAT;
        end
      end
      m_prev[c] = b;
    end
    presc = tk ? 0 : presc + 1;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("evt_valid", 8'(evt_valid), 8'(q_btn.size() != 0));
    if (q_btn.size() != 0) begin
      chk("evt_btn", 8'(evt_btn), 8'(q_btn[0]));
      chk("evt_type", 8'(evt_type), 8'(q_typ[0]));
    end
    chk("overflow", 8'(overflow), 8'(m_ovf));
  endtask

  initial begin
    // Reset state
    n_rst = 1'b0;
    cyc();
    cyc();
    chk("rst_evt_btn", 8'(evt_btn), 8'd0);
    chk("rst_evt_type", 8'(evt_type), 8'd0);
    n_rst = 1'b1;
    repeat (3) cyc();

    // Short press on channel 2: valid two edges after the sampling edge
    btn_i[2] = 1'b1;
    cyc();
    cyc();
    chk("lat_not_yet", 8'(evt_valid), 8'd0);
    cyc();
    chk("lat_valid", 8'(evt_valid), 8'd1);
    chk("lat_btn", 8'(evt_btn), 8'd2);
    chk("lat_type", 8'(evt_type), 8'(T_PRESS));
    repeat (5) cyc();
    btn_i[2] = 1'b0;
    repeat (6) cyc();

    // Long hold on channel 1: LONG then REPEATs
    btn_i[1] = 1'b1;
    repeat (36) cyc();
    btn_i[1] = 1'b0;
    repeat (6) cyc();

    // All four at once, then all released
    btn_i = 4'b1111;
    repeat (8) cyc();
    btn_i = 4'b0000;
    repeat (8) cyc();

    // Consumer stalled: fill FIFO, then overwrite a pending slot on channel 0
    evt_ready = 1'b0;
    btn_i = 4'b1110;
    repeat (4) cyc();
    btn_i[1] = 1'b0;
    repeat (3) cyc();
    btn_i[0] = 1'b1;
    repeat (2) cyc();
    btn_i[0] = 1'b0;
    repeat (2) cyc();
    chk("ovf_after_overwrite", 8'(overflow), 8'd1);
    btn_i = 4'b0000;
    evt_ready = 1'b1;
    repeat (12) cyc();

    // clr_ovf alone clears; clr_ovf colliding with an overwrite loses
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 8'(overflow), 8'd0);
    evt_ready = 1'b0;
    btn_i = 4'b1111;
    repeat (6) cyc();
    btn_i = 4'b0000;
    repeat (3) cyc();
    btn_i[0] = 1'b1;
    cyc();
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("ovf_set_beats_clr", 8'(overflow), 8'd1);
    btn_i = 4'b0000;
    evt_ready = 1'b1;
    repeat (14) cyc();
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;

    // Mid-operation reset with channel 1 still held
    evt_ready = 1'b0;
    btn_i = 4'b0111;
    repeat (5) cyc();
    btn_i = 4'b0010;
    n_rst = 1'b0;
    cyc();
    chk("midrst_valid", 8'(evt_valid), 8'd0);
    chk("midrst_ovf", 8'(overflow), 8'd0);
    n_rst = 1'b1;
    evt_ready = 1'b1;
    cyc();
    cyc();
    chk("post_rst_not_yet", 8'(evt_valid), 8'd0);
    cyc();
    chk("post_rst_valid", 8'(evt_valid), 8'd1);
    chk("post_rst_btn", 8'(evt_btn), 8'd1);
    chk("post_rst_type", 8'(evt_type), 8'(T_PRESS));
    btn_i = 4'b0000;
    repeat (6) cyc();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) btn_i[$urandom_range(0, N - 1)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      n_rst     = ($urandom_range(0, 399) != 0);
      cyc();
    end
    n_rst = 1'b1;
    clr_ovf = 1'b0;
    btn_i = '0;
    evt_ready = 1'b1;
    repeat (12) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_evt_ctrl.md
Name: btn_evt_ctrl

Overview:
- Multi-button event scheduler placed downstream of the per-button debouncers.
- Converts each debounced level into PRESS / RELEASE / LONG / REPEAT events using one shared millisecond prescaler.
- Arbitrates per-channel pending events round-robin into a small event FIFO.
- The FIFO drains to the consumer (PS register block or menu FSM) over a valid/ready handshake.

Parameters:
- NBTN, 4, number of button channels (2..8).
- TICK_DIV, 100000, clk cycles per tick (1 ms at 100 MHz).
- LONG_TICKS, 500, ticks held before the LONG event.
- REPEAT_TICKS, 100, ticks between REPEAT events after LONG.
- FIFO_DEPTH, 4, event FIFO entries (power of 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- n_rst  in  1  reset; synchronous, active-low.
- btn_i  in  NBTN  debounced button levels; 1 = pressed.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_btn  out  clog2(NBTN)  channel index of the head entry.
- evt_type  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
- overflow  out  1  sticky: a pending event was overwritten.
- clr_ovf  in  1  single-cycle clear of overflow.

Behaviour:
- Reset:
  - Applies when n_rst = 0 at a clk edge.
  - Prescaler = 0; every channel in IDLE with hold_cnt = 0, prev = 0, pend = 0.
  - FIFO empty; rr_ptr = NBTN-1.
  - evt_valid = 0, evt_btn = 0, evt_type = 0, overflow = 0.
  - A button already held when reset deasserts produces a PRESS.
  - Reset mid-operation discards all FIFO contents and all pending events.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle pulse while the count equals TICK_DIV-1, so the first tick falls on the TICK_DIV-th cycle after reset.
- Per-channel edge detect:
  - prev <= btn_i each cycle.
  - rise = btn_i & ~prev; fall = ~btn_i & prev.
- Per-channel FSM (states IDLE, DOWN, HELD):
  - IDLE: on rise -> DOWN, hold_cnt = 0, post PRESS.
  - DOWN: on tick hold_cnt++. On the tick where hold_cnt == LONG_TICKS-1 -> HELD, hold_cnt = 0, post LONG.
  - HELD: on tick hold_cnt++. On the tick where hold_cnt == REPEAT_TICKS-1 -> hold_cnt = 0, post REPEAT.
  - DOWN or HELD: on fall -> IDLE, post RELEASE. Fall has priority over a simultaneous tick event.
  - hold_cnt width is clog2(max(LONG_TICKS, REPEAT_TICKS)) and never wraps.
- Pending slot (one per channel: pend flag + 2-bit type):
  - Posting while pend = 1 and the slot is not granted in the same cycle overwrites the type with the newest event and sets overflow.
  - Posting in the same cycle as a grant of that slot loads the new event with no overflow.
  - overflow set has priority over clr_ovf.
- Arbiter:
  - Active when the FIFO is not full: grants the first pend channel searching from rr_ptr+1 modulo NBTN.
  - On grant: writes {idx, type} into the FIFO, clears that pend, sets rr_ptr = idx.
  - At most one grant per cycle.
  - FIFO full: no grant; pending events are held, not dropped.
- FIFO:
  - evt_valid / evt_btn / evt_type come from the head register.
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle are allowed whenever not full; occupancy is then unchanged.
  - Push is blocked when full, even if a pop occurs that cycle.
  - Head data is stable while evt_valid = 1 and evt_ready = 0.
- Latency with an idle FIFO:
  - btn_i first sampled changed at edge k -> pend set at edge k+1 -> FIFO write at edge k+2 -> evt_valid = 1 after edge k+2.

Decomposition:
- Package btn_evt_pkg holds: the event-type codes EVT_PRESS, EVT_RELEASE, EVT_LONG, EVT_REPEAT; the state encodings; and the clog2 function.
- Sub-module btn_evt_fifo (parameterised depth/width, synchronous FIFO with full/empty) is the one natural split.
- The per-channel FSM stays inline in a generate loop.

Test Plan (NBTN=4, TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, FIFO_DEPTH=4, evt_ready=1 unless noted):
- Press btn_i[2] for 2 ticks, then release -> exactly {2,PRESS}, then {2,RELEASE}; first evt_valid 2 cycles after the edge; no LONG.
- Hold btn_i[1] for 9 ticks -> {1,PRESS}; {1,LONG} on the 3rd tick after press; {1,REPEAT} on ticks 5 and 7 (and 9 if held); {1,RELEASE} on release.
- Raise btn_i[3:0] = 4'b1111 in one cycle -> four PRESS events in order 0,1,2,3 on consecutive cycles; a later simultaneous release also comes out in order 0,1,2,3.
- evt_ready = 0 with 4 events queued, then press btn_i[0] -> evt_valid held with head unchanged and btn 0 pending. Release btn_i[0] before drain -> overflow = 1, the slot holds RELEASE. Set evt_ready = 1 -> original 4 events, then {0,RELEASE}.
- clr_ovf pulse -> overflow = 0; clr_ovf in the same cycle as a new overwrite -> overflow stays 1.
- Pull n_rst low for 1 cycle with 3 events queued and btn_i[1] held -> evt_valid = 0 and overflow = 0 the next cycle; then a fresh {1,PRESS} appears 2 cycles after reset release.
